// File: rtl/control_wave_pkg.sv
// Shared definitions for the control_wave block: default parameter values,
// master FSM state encoding and a width helper for index/counter signals.
package control_wave_pkg;

  localparam int unsigned DEF_N_CARS     = 4;
  localparam int unsigned DEF_MAX_HP     = 3;
  localparam int unsigned DEF_SPAWN_GAP  = 60;
  localparam int unsigned DEF_PATH_STEPS = 160;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_SCAN,
    ST_ERASE,
    ST_STEP,
    ST_DRAW,
    ST_NEXT,
    ST_DONE
  } state_e;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/control_wave_if.sv
// Handshake/status bundle between the wave controller and its environment.
//   initiate, enable_draw      : wave start / frame tick pulses
//   hit[N_CARS]                : per-car damage pulses
//   erase_done, draw_done      : drawer completion pulses
//   car_sel                    : index of the car being serviced
//   erase_car/increment/draw_car : drawer/datapath commands for car_sel
//   active/destroyed/leaked    : per-car status
//   wave_busy/wave_done/frame_miss : wave status and overrun pulse
// slave = the controller, master = the environment driving it.
interface control_wave_if
  import control_wave_pkg::*;
#(
  parameter int unsigned N_CARS = DEF_N_CARS
);

  localparam int unsigned SEL_W = sel_width(N_CARS);

  logic              initiate;
  logic              enable_draw;
  logic [N_CARS-1:0] hit;
  logic              erase_done;
  logic              draw_done;
  logic [SEL_W-1:0]  car_sel;
  logic              erase_car;
  logic              increment;
  logic              draw_car;
  logic [N_CARS-1:0] active;
  logic [N_CARS-1:0] destroyed;
  logic [N_CARS-1:0] leaked;
  logic              wave_busy;
  logic              wave_done;
  logic              frame_miss;

  modport slave (
    input  initiate, enable_draw, hit, erase_done, draw_done,
    output car_sel, erase_car, increment, draw_car,
           active, destroyed, leaked, wave_busy, wave_done, frame_miss
  );

  modport master (
    output initiate, enable_draw, hit, erase_done, draw_done,
    input  car_sel, erase_car, increment, draw_car,
           active, destroyed, leaked, wave_busy, wave_done, frame_miss
  );

endinterface

// File: rtl/car_slot.sv
// One car slot: hit points, path position and sticky per-wave status.
//   clk, reset  : clock, asynchronous active-high reset
//   clear_i     : start of a new wave, wipes everything
//   spawn_i     : bring the car to life at full hp, step 0 (beats hit_i)
//   hit_i       : damage pulse, ignored unless the car is active
//   step_i      : advance one step along the path
//   active_o, destroyed_o, leaked_o : status
//   at_end_o    : the next step reaches the end of the path
module car_slot
  import control_wave_pkg::*;
#(
  parameter int unsigned MAX_HP     = DEF_MAX_HP,
  parameter int unsigned PATH_STEPS = DEF_PATH_STEPS
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic spawn_i,
  input  logic hit_i,
  input  logic step_i,
  output logic active_o,
  output logic destroyed_o,
  output logic leaked_o,
  output logic at_end_o
);

  localparam int unsigned STEP_W = $clog2(PATH_STEPS + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(PATH_STEPS - 1);

  logic [3:0]        hp_q, hp_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              active_q, active_d;
  logic              destroyed_q, destroyed_d;
  logic              leaked_q, leaked_d;
  logic              killed;

  always_comb begin
    hp_d        = hp_q;
    step_d      = step_q;
    active_d    = active_q;
    destroyed_d = destroyed_q;
    leaked_d    = leaked_q;
    killed      = 1'b0;
    if (clear_i) begin
      hp_d        = '0;
      step_d      = '0;
      active_d    = 1'b0;
      destroyed_d = 1'b0;
      leaked_d    = 1'b0;
    end else if (spawn_i) begin
      active_d = 1'b1;
      hp_d     = 4'(MAX_HP);
      step_d   = '0;
    end else if (active_q) begin
      killed = hit_i && (hp_q == 4'd1);
      if (hit_i) hp_d = hp_q - 4'd1;
      if (step_i) step_d = step_q + STEP_W'(1);
      // A kill landing on the final step counts as destroyed, not leaked.
      if (killed) begin
        active_d    = 1'b0;
        destroyed_d = 1'b1;
      end else if (step_i && (step_q == LAST_STEP)) begin
        active_d = 1'b0;
        leaked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hp_q        <= '0;
      step_q      <= '0;
      active_q    <= 1'b0;
      destroyed_q <= 1'b0;
      leaked_q    <= 1'b0;
    end else begin
      hp_q        <= hp_d;
      step_q      <= step_d;
      active_q    <= active_d;
      destroyed_q <= destroyed_d;
      leaked_q    <= leaked_d;
    end
  end

  assign active_o    = active_q;
  assign destroyed_o = destroyed_q;
  assign leaked_o    = leaked_q;
  assign at_end_o    = active_q && (step_q == LAST_STEP);

endmodule

// File: rtl/control_wave.sv
// Wave controller: master FSM that services each car slot once per frame
// (erase, step, redraw), spawns cars on a fixed frame schedule and reports
// wave progress.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : control_wave_if slave modport (commands, drawer handshake,
//                per-car status, wave status)
module control_wave
  import control_wave_pkg::*;
#(
  parameter int unsigned N_CARS     = DEF_N_CARS,
  parameter int unsigned MAX_HP     = DEF_MAX_HP,
  parameter int unsigned SPAWN_GAP  = DEF_SPAWN_GAP,
  parameter int unsigned PATH_STEPS = DEF_PATH_STEPS
) (
  input  logic           clk,
  input  logic           reset,
  control_wave_if.slave  bus
);

  localparam int unsigned SEL_W = sel_width(N_CARS);
  localparam int unsigned CNT_W = $clog2(N_CARS + 1);
  localparam int unsigned GAP_W = sel_width(SPAWN_GAP);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  spawned_q, spawned_d;
  logic [GAP_W-1:0]  gap_q, gap_d;      // accepted frames left until next spawn
  logic              miss_q, miss_d;
  logic              clear;
  logic              spawn_now;
  logic [N_CARS-1:0] spawn_vec, step_vec;
  logic [N_CARS-1:0] active, destroyed, leaked, at_end;
  logic              cur_active, cur_at_end;

  genvar g;
  generate
    for (g = 0; g < N_CARS; g++) begin : g_slot
      car_slot #(
        .MAX_HP     (MAX_HP),
        .PATH_STEPS (PATH_STEPS)
      ) u_slot (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear),
        .spawn_i     (spawn_vec[g]),
        .hit_i       (bus.hit[g]),
        .step_i      (step_vec[g]),
        .active_o    (active[g]),
        .destroyed_o (destroyed[g]),
        .leaked_o    (leaked[g]),
        .at_end_o    (at_end[g])
      );
    end
  endgenerate

  assign cur_active = active[sel_q];
  assign cur_at_end = at_end[sel_q];

  always_comb begin
    spawn_vec = '0;
    step_vec  = '0;
    for (int unsigned i = 0; i < N_CARS; i++) begin
      spawn_vec[i] = spawn_now && (spawned_q == CNT_W'(i));
      step_vec[i]  = (state_q == ST_STEP) && (sel_q == SEL_W'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    spawned_d = spawned_q;
    gap_d     = gap_q;
    clear     = 1'b0;
    spawn_now = 1'b0;
    miss_d    = bus.enable_draw && (state_q != ST_IDLE) &&
                (state_q != ST_WAIT_FRAME) && (state_q != ST_DONE);
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.initiate) begin
          clear     = 1'b1;
          spawned_d = '0;
          gap_d     = '0;
          state_d   = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (bus.enable_draw) begin
          sel_d   = '0;
          state_d = ST_SCAN;
          if ((spawned_q != CNT_W'(N_CARS)) && (gap_q == '0)) begin
            spawn_now = 1'b1;
            spawned_d = spawned_q + CNT_W'(1);
            gap_d     = GAP_W'(SPAWN_GAP - 1);
          end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
      end
      ST_SCAN: state_d = cur_active ? ST_ERASE : ST_NEXT;
      ST_ERASE: begin
        if (bus.erase_done) state_d = cur_active ? ST_STEP : ST_NEXT;
      end
      // at_end reflects the pre-increment step, i.e. this step hits the end.
      ST_STEP: state_d = (!cur_active || cur_at_end) ? ST_NEXT : ST_DRAW;
      ST_DRAW: begin
        if (bus.draw_done) state_d = cur_active ? ST_NEXT : ST_ERASE;
      end
      ST_NEXT: begin
        if (sel_q == SEL_W'(N_CARS - 1)) begin
          state_d = ((spawned_q == CNT_W'(N_CARS)) && (active == '0))
                    ? ST_DONE : ST_WAIT_FRAME;
        end else begin
          sel_d   = sel_q + SEL_W'(1);
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      spawned_q <= '0;
      gap_q     <= '0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      spawned_q <= spawned_d;
      gap_q     <= gap_d;
      miss_q    <= miss_d;
    end
  end

  always_comb begin
    bus.car_sel    = sel_q;
    bus.erase_car  = (state_q == ST_ERASE);
    bus.increment  = (state_q == ST_STEP);
    bus.draw_car   = (state_q == ST_DRAW);
    bus.active     = active;
    bus.destroyed  = destroyed;
    bus.leaked     = leaked;
    bus.wave_busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    bus.wave_done  = (state_q == ST_DONE);
    bus.frame_miss = miss_q;
  end

endmodule
